// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr
// Round-robin arbiter sharing one pipelined Wishbone slave port between
// NUM bus masters. Ownership is granted for a whole bus cycle (cyc), so one
// master's burst is never interleaved with another's. A per-cycle watchdog
// takes the bus back from a master whose slave never answers.
//
// Ports
//   clk_i, rst_i                  bus clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i        per-master cycle, strobe, write-enable
//   m_adr_i, m_dat_i              packed per-master address / write data
//                                 (master k at [k*ABITS +: ABITS] / [k*WIDTH +: WIDTH])
//   m_ack_o/m_wat_o/m_rty_o/m_err_o  per-master responses
//   m_dat_o                       read data, broadcast to every master
//   s_cyc_o/s_stb_o/s_we_o        slave cycle, strobe, write-enable
//   s_adr_o, s_dat_o              slave address / write data
//   s_ack_i/s_wat_i/s_rty_i/s_err_i  slave responses
//   s_dat_i                       slave read data
//   grant_o                       registered one-hot grant, zero when no owner
//   timeout_o                     one-cycle pulse after the watchdog fires
module wb_arbiter_rr #(
    parameter int NUM   = 2,
    parameter int WIDTH = 8,
    parameter int ABITS = 7,
    parameter int LIMIT = 255,
    parameter int DELAY = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM-1:0]       m_cyc_i,
    input  logic [NUM-1:0]       m_stb_i,
    input  logic [NUM-1:0]       m_we_i,
    input  logic [NUM*ABITS-1:0] m_adr_i,
    input  logic [NUM*WIDTH-1:0] m_dat_i,
    output logic [NUM-1:0]       m_ack_o,
    output logic [NUM-1:0]       m_wat_o,
    output logic [NUM-1:0]       m_rty_o,
    output logic [NUM-1:0]       m_err_o,
    output logic [WIDTH-1:0]     m_dat_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [ABITS-1:0]     s_adr_o,
    output logic [WIDTH-1:0]     s_dat_o,
    input  logic                 s_ack_i,
    input  logic                 s_wat_i,
    input  logic                 s_rty_i,
    input  logic                 s_err_i,
    input  logic [WIDTH-1:0]     s_dat_i,
    output logic [NUM-1:0]       grant_o,
    output logic                 timeout_o
);

    localparam int IW = (NUM > 2) ? 2 : 1;
    localparam int WW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(LIMIT - 1);

    // DELAY only matters to behavioural models; this RTL carries no delays,
    // so the parameter is just sanity-checked together with NUM.
    if (NUM < 2 || NUM > 4 || DELAY < 0) begin : g_bad_params
        $error("wb_arbiter_rr: NUM must be 2..4 and DELAY non-negative");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NUM-1:0]  grant_q, grant_d;
    logic [WW-1:0]   wdt_q, wdt_d;
    logic            timeout_q, timeout_d;

    logic [IW-1:0]   winner;
    logic            own_cyc, own_stb, own_we;
    logic [ABITS-1:0] own_adr;
    logic [WIDTH-1:0] own_dat;
    logic            resp;
    logic            fire;

    assign resp = s_ack_i | s_rty_i | s_err_i;

    // Rotating priority search: scanning offsets from NUM down to 1 means the
    // last hit is the requester closest after last_q, which is the winner.
    always_comb begin
        winner = last_q;
        for (int i = NUM; i >= 1; i--) begin
            for (int k = 0; k < NUM; k++) begin
                if (((int'(last_q) + i) % NUM) == k && m_cyc_i[k]) begin
                    winner = IW'(k);
                end
            end
        end
    end

    // Signals of the current (or most recent) owner; the slave side is only
    // qualified by s_cyc_o, so driving these in IDLE/DRAIN is harmless.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        for (int k = 0; k < NUM; k++) begin
            if (owner_q == IW'(k)) begin
                own_cyc = m_cyc_i[k];
                own_stb = m_stb_i[k];
                own_we  = m_we_i[k];
                own_adr = m_adr_i[k*ABITS +: ABITS];
                own_dat = m_dat_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // The owner dropping cyc on the limit cycle is a normal release, so the
    // watchdog only fires while the owner still holds the cycle open.
    assign fire = (LIMIT != 0) && (state_q == BUSY) && own_cyc && !resp
                  && (wdt_q == WDT_LAST);

    // Bus routing: only a BUSY owner reaches the slave; everyone else stalls.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = own_we;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        m_ack_o = '0;
        m_rty_o = '0;
        m_err_o = '0;
        m_wat_o = '1;
        m_dat_o = s_dat_i;
        if (state_q == BUSY) begin
            s_cyc_o = own_cyc;
            s_stb_o = own_cyc & own_stb;
            for (int k = 0; k < NUM; k++) begin
                if (owner_q == IW'(k)) begin
                    m_ack_o[k] = s_ack_i;
                    m_rty_o[k] = s_rty_i;
                    m_err_o[k] = s_err_i | fire;
                    m_wat_o[k] = s_wat_i;
                end
            end
        end
    end

    // Next-state logic for ownership, grant and watchdog.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        grant_d   = grant_q;
        wdt_d     = wdt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d = BUSY;
                    owner_d = winner;
                    last_d  = winner;
                    wdt_d   = '0;
                    grant_d = '0;
                    for (int k = 0; k < NUM; k++) begin
                        if (winner == IW'(k)) begin
                            grant_d[k] = 1'b1;
                        end
                    end
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (fire) begin
                    state_d   = DRAIN;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else if (resp || LIMIT == 0) begin
                    wdt_d = '0;
                end else begin
                    wdt_d = wdt_q + WW'(1);
                end
            end
            DRAIN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= IW'(NUM - 1);
            grant_q   <= '0;
            wdt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            wdt_q     <= wdt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr
// Self-checking bench for wb_arbiter_rr with three masters and an 8-cycle
// watchdog. A table of per-cycle vectors covers reset, single-master bursts,
// rotation, watchdog timeout, the limit-cycle ack and release-on-limit;
// hand-written sequences cover reset mid-burst, contention and fairness.
module tb_wb_arbiter_rr;

    localparam int NUM   = 3;
    localparam int WIDTH = 8;
    localparam int ABITS = 7;

    logic                 clk_i;
    logic                 rst_i;
    logic [NUM-1:0]       m_cyc_i, m_stb_i, m_we_i;
    logic [NUM*ABITS-1:0] m_adr_i;
    logic [NUM*WIDTH-1:0] m_dat_i;
    logic [NUM-1:0]       m_ack_o, m_wat_o, m_rty_o, m_err_o;
    logic [WIDTH-1:0]     m_dat_o;
    logic                 s_cyc_o, s_stb_o, s_we_o;
    logic [ABITS-1:0]     s_adr_o;
    logic [WIDTH-1:0]     s_dat_o;
    logic                 s_ack_i, s_wat_i, s_rty_i, s_err_i;
    logic [WIDTH-1:0]     s_dat_i;
    logic [NUM-1:0]       grant_o;
    logic                 timeout_o;

    int n_compared = 0;
    int n_mismatched = 0;

    wb_arbiter_rr #(
        .NUM(NUM), .WIDTH(WIDTH), .ABITS(ABITS), .LIMIT(8), .DELAY(3)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_wat_o(m_wat_o), .m_rty_o(m_rty_o), .m_err_o(m_err_o),
        .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_wat_i(s_wat_i), .s_rty_i(s_rty_i), .s_err_i(s_err_i),
        .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #50000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] bench did not terminate");
    end

    typedef struct {
        logic       rst;
        logic [2:0] cyc;
        logic [2:0] stb;
        logic       ack;
        logic [2:0] grant;
        logic       scyc;
        logic       sstb;
        logic [2:0] mack;
        logic [2:0] mwat;
        logic [2:0] merr;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [2:0] cyc, input logic [2:0] stb,
                       input logic ack, input logic [2:0] grant, input logic scyc,
                       input logic sstb, input logic [2:0] mack, input logic [2:0] mwat,
                       input logic [2:0] merr, input logic tmo);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack;
        v.grant = grant; v.scyc = scyc; v.sstb = sstb;
        v.mack = mack; v.mwat = mwat; v.merr = merr; v.tmo = tmo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst_i   = v.rst;
        m_cyc_i = v.cyc;
        m_stb_i = v.stb;
        s_ack_i = v.ack;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check($sformatf("row%0d grant", idx),   32'(grant_o),   32'(v.grant));
        check($sformatf("row%0d s_cyc", idx),   32'(s_cyc_o),   32'(v.scyc));
        check($sformatf("row%0d s_stb", idx),   32'(s_stb_o),   32'(v.sstb));
        check($sformatf("row%0d m_ack", idx),   32'(m_ack_o),   32'(v.mack));
        check($sformatf("row%0d m_wat", idx),   32'(m_wat_o),   32'(v.mwat));
        check($sformatf("row%0d m_err", idx),   32'(m_err_o),   32'(v.merr));
        check($sformatf("row%0d timeout", idx), 32'(timeout_o), 32'(v.tmo));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = {7'h33, 7'h22, 7'h11};
        m_dat_i = {8'hC3, 8'hB2, 8'hA1};
        s_ack_i = 1'b0;
        s_wat_i = 1'b0;
        s_rty_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = 8'h5A;

        // Reset state, then master 0 three-beat read.
        add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        add(0, 3'b001, 3'b001, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        add(0, 3'b001, 3'b001, 0, 3'b001, 1, 1, 3'b000, 3'b110, 3'b000, 0);
        for (int i = 0; i < 3; i++)
            add(0, 3'b001, 3'b001, 1, 3'b001, 1, 1, 3'b001, 3'b110, 3'b000, 0);
        add(0, 3'b000, 3'b000, 0, 3'b001, 0, 0, 3'b000, 3'b110, 3'b000, 0);
        add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        // Masters 0 and 1 request with last = 0: rotation gives master 1 first.
        add(0, 3'b011, 3'b011, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        add(0, 3'b011, 3'b011, 0, 3'b010, 1, 1, 3'b000, 3'b101, 3'b000, 0);
        add(0, 3'b011, 3'b011, 1, 3'b010, 1, 1, 3'b010, 3'b101, 3'b000, 0);
        add(0, 3'b001, 3'b001, 0, 3'b010, 0, 0, 3'b000, 3'b101, 3'b000, 0);
        add(0, 3'b001, 3'b001, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        add(0, 3'b001, 3'b001, 1, 3'b001, 1, 1, 3'b001, 3'b110, 3'b000, 0);
        add(0, 3'b000, 3'b000, 0, 3'b001, 0, 0, 3'b000, 3'b110, 3'b000, 0);
        add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        // Watchdog: master 2 never gets a response, master 0 waits behind it.
        add(0, 3'b100, 3'b100, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        add(0, 3'b100, 3'b100, 0, 3'b100, 1, 1, 3'b000, 3'b011, 3'b000, 0);
        for (int i = 0; i < 6; i++)
            add(0, 3'b101, 3'b101, 0, 3'b100, 1, 1, 3'b000, 3'b011, 3'b000, 0);
        add(0, 3'b101, 3'b101, 0, 3'b100, 1, 1, 3'b000, 3'b011, 3'b100, 0);
        add(0, 3'b101, 3'b101, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 1);
        add(0, 3'b101, 3'b101, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        add(0, 3'b001, 3'b001, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        add(0, 3'b001, 3'b001, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        add(0, 3'b001, 3'b001, 1, 3'b001, 1, 1, 3'b001, 3'b110, 3'b000, 0);
        add(0, 3'b000, 3'b000, 0, 3'b001, 0, 0, 3'b000, 3'b110, 3'b000, 0);
        add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        // Ack on the limit cycle, then the count restarts from zero.
        add(0, 3'b010, 3'b010, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        for (int i = 0; i < 7; i++)
            add(0, 3'b010, 3'b010, 0, 3'b010, 1, 1, 3'b000, 3'b101, 3'b000, 0);
        add(0, 3'b010, 3'b010, 1, 3'b010, 1, 1, 3'b010, 3'b101, 3'b000, 0);
        for (int i = 0; i < 7; i++)
            add(0, 3'b010, 3'b010, 0, 3'b010, 1, 1, 3'b000, 3'b101, 3'b000, 0);
        add(0, 3'b010, 3'b010, 0, 3'b010, 1, 1, 3'b000, 3'b101, 3'b010, 0);
        add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 1);
        add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        // Owner releases on the limit cycle: release wins, no err/timeout.
        add(0, 3'b001, 3'b001, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);
        for (int i = 0; i < 7; i++)
            add(0, 3'b001, 3'b001, 0, 3'b001, 1, 1, 3'b000, 3'b110, 3'b000, 0);
        add(0, 3'b000, 3'b000, 0, 3'b001, 0, 0, 3'b000, 3'b110, 3'b000, 0);
        add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b111, 3'b000, 0);

        step();
        step();
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk_i);
            check_output(vecs[i], i);
            step();
        end

        // Reset in the middle of a master 1 write burst.
        m_cyc_i = 3'b010; m_stb_i = 3'b010; m_we_i = 3'b010; s_ack_i = 1'b0;
        @(negedge clk_i);
        check("wr idle grant", 32'(grant_o), 32'h0);
        step();
        s_ack_i = 1'b1;
        @(negedge clk_i);
        check("wr grant", 32'(grant_o), 32'h2);
        check("wr s_we", 32'(s_we_o), 32'h1);
        check("wr s_adr", 32'(s_adr_o), 32'h22);
        check("wr s_dat", 32'(s_dat_o), 32'hB2);
        check("wr beat1 ack", 32'(m_ack_o), 32'h2);
        step();
        s_ack_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        check("wr beat2 s_cyc", 32'(s_cyc_o), 32'h1);
        step();
        rst_i = 1'b0; m_cyc_i = 3'b011; m_stb_i = 3'b011; s_ack_i = 1'b1;
        @(negedge clk_i);
        check("post-reset s_cyc", 32'(s_cyc_o), 32'h0);
        check("post-reset grant", 32'(grant_o), 32'h0);
        check("post-reset ack", 32'(m_ack_o), 32'h0);
        check("post-reset wat", 32'(m_wat_o), 32'h7);
        step();
        // Contention right after reset: master 0 wins, master 1 stalls.
        @(negedge clk_i);
        check("cont grant0", 32'(grant_o), 32'h1);
        check("cont s_adr0", 32'(s_adr_o), 32'h11);
        check("cont s_we0", 32'(s_we_o), 32'h0);
        check("cont rdata", 32'(m_dat_o), 32'h5A);
        check("cont ack0", 32'(m_ack_o), 32'h1);
        check("cont wat", 32'(m_wat_o), 32'h6);
        step();
        s_dat_i = 8'h3C;
        @(negedge clk_i);
        check("cont rdata2", 32'(m_dat_o), 32'h3C);
        check("cont wat1 held", 32'(m_wat_o[1]), 32'h1);
        step();
        m_cyc_i = 3'b010; m_stb_i = 3'b010; s_ack_i = 1'b0;
        @(negedge clk_i);
        check("cont drop grant", 32'(grant_o), 32'h1);
        check("cont drop wat1", 32'(m_wat_o[1]), 32'h1);
        step();
        @(negedge clk_i);
        check("cont dead cycle", 32'(grant_o), 32'h0);
        check("cont dead wat1", 32'(m_wat_o[1]), 32'h1);
        step();
        @(negedge clk_i);
        check("cont grant1", 32'(grant_o), 32'h2);
        check("cont s_adr1", 32'(s_adr_o), 32'h22);
        check("cont wat1 free", 32'(m_wat_o), 32'h5);
        step();
        m_cyc_i = 3'b000; m_stb_i = 3'b000; m_we_i = 3'b000;
        step();

        // Fairness: three masters re-requesting single-beat cycles.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int n = 0; n < 6; n++) begin
            logic [2:0] e;
            e = 3'(1 << (n % 3));
            m_cyc_i = 3'b111; m_stb_i = 3'b111; s_ack_i = 1'b0;
            @(negedge clk_i);
            check($sformatf("fair%0d idle", n), 32'(grant_o), 32'h0);
            step();
            s_ack_i = 1'b1;
            @(negedge clk_i);
            check($sformatf("fair%0d grant", n), 32'(grant_o), 32'(e));
            check($sformatf("fair%0d ack", n), 32'(m_ack_o), 32'(e));
            step();
            m_cyc_i = ~e; m_stb_i = ~e; s_ack_i = 1'b0;
            @(negedge clk_i);
            check($sformatf("fair%0d release", n), 32'(s_cyc_o), 32'h0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_rr.md
# wb_arbiter_rr

Round-robin arbiter that shares one pipelined Wishbone (SPEC B4) slave port, typically the TART register bank, between up to four bus masters. Masters include the SPI-slave bridge, the acquisition controller and the DSP scheduler. Ownership is granted per bus cycle (`cyc`), so bursts from one master are never interleaved with another. A per-cycle watchdog reclaims the bus from a master whose slave never responds.

## Interface
- `NUM`, 2 — number of masters, 2..4.
- `WIDTH`, 8 — data-bus width.
- `ABITS`, 7 — address width.
- `LIMIT`, 255 — watchdog limit, in cycles without a response; 0 disables the watchdog.
- `DELAY`, 3 — simulation-only assignment delay.
- `clk_i`  in  1  bus clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  NUM  per-master cycle, strobe, write-enable.
- `m_adr_i`  in  NUM*ABITS  packed addresses; master k occupies bits [k*ABITS +: ABITS].
- `m_dat_i`  in  NUM*WIDTH  packed write data.
- `m_ack_o`, `m_wat_o`, `m_rty_o`, `m_err_o`  out  NUM  per-master responses.
- `m_dat_o`  out  WIDTH  read data, broadcast to all masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave cycle, strobe, write-enable.
- `s_adr_o`  out  ABITS  slave address.
- `s_dat_o`  out  WIDTH  slave write data.
- `s_ack_i`, `s_wat_i`, `s_rty_i`, `s_err_i`  in  1  slave responses.
- `s_dat_i`  in  WIDTH  slave read data.
- `grant_o`  out  NUM  registered one-hot grant; all zero when no master owns the bus.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States:
  - `IDLE`: no owner.
  - `BUSY`: one master owns the slave port.
  - `DRAIN`: ownership revoked by the watchdog; waiting for the offending master to drop `cyc`.
- **IDLE**: if any `m_cyc_i` is high, select the first requester searching from `last+1` modulo NUM. On the next edge, register `grant_o`, record the winner in `last`, and enter BUSY.
- **BUSY** with owner g:
  - `s_cyc_o = m_cyc_i[g]`, `s_stb_o = m_cyc_i[g] & m_stb_i[g]`.
  - `s_we_o`, `s_adr_o`, `s_dat_o` are muxed from master g.
  - `m_ack_o[g] = s_ack_i`, with `rty`, `err` and `wat` routed the same way.
  - Non-owners see `m_wat_o = 1` and `ack`/`rty`/`err` = 0.
- **Release**: when `m_cyc_i[g]` falls in BUSY, clear `grant_o` on the next edge and return to IDLE. This leaves exactly one dead cycle between owners.
- **Watchdog** (`LIMIT` ≠ 0):
  - Counter `wdt` clears on entry to BUSY and on any `s_ack_i`, `s_rty_i` or `s_err_i`.
  - It increments on every other BUSY cycle.
  - When `wdt == LIMIT-1` and no response arrives that cycle, the arbiter:
    - asserts `m_err_o[g]` combinationally that cycle;
    - pulses `timeout_o` (registered, next cycle);
    - enters DRAIN.
- **DRAIN**:
  - `grant_o` = 0, `s_cyc_o` = `s_stb_o` = 0.
  - `m_wat_o[g]` = 1, other outputs to g are 0.
  - When `m_cyc_i[g]` is low, return to IDLE. Other requesters wait.
- `m_dat_o` is always driven from `s_dat_i`; a master qualifies it with its own `ack`.
- A master that raises `cyc` while another owns the bus is held stalled (`m_wat_o` = 1) until its grant.

## Timing
- Reset values:
  - state = IDLE, `grant_o` = 0, `last` = NUM-1 (master 0 wins first), `wdt` = 0, `timeout_o` = 0.
  - `s_cyc_o` = `s_stb_o` = 0; all `m_ack`/`rty`/`err` = 0; all `m_wat_o` = 1.
- Grant latency: `m_cyc_i` rising at edge n → `grant_o` and `s_cyc_o` high after edge n+1. A strobe already high is presented to the slave at cycle n+1.
- The slave path is combinational; the arbiter adds no pipeline registers.
- Simultaneous requests: the rotating priority guarantees each of the NUM requesters a grant within NUM grants.
- Owner drops `cyc` in the same cycle the watchdog limit is reached: the release takes precedence. No `err`, no `timeout_o`, go to IDLE.
- A response arriving on the limit cycle clears `wdt`; no timeout.
- `rst_i` mid-cycle forces reset values on the next edge regardless of state. Masters see `ack` = 0 from then on.
- Grant bit index k out of range (k ≥ NUM) is impossible by construction; an illegal state decodes to IDLE.

## Test plan
- **Single master**: master 0 requests at edge 10 with a 3-beat read; slave acks at 12, 13, 14 → `grant_o` = 01 from edge 11, three `m_ack_o[0]` pulses, data matches, `grant_o` = 00 one cycle after `cyc` drops.
- **Contention**: masters 0 and 1 both raise `cyc` at edge 5 → master 0 is granted first. Master 1 sees `m_wat_o[1]` = 1 throughout, then is granted exactly two cycles after master 0 drops `cyc`.
- **Fairness**: NUM=3, all masters requesting continuously with single-beat cycles → grant sequence 0, 1, 2, 0, 1, 2.
- **Watchdog**: LIMIT=8, slave never acks → `m_err_o[g]` high on the 8th BUSY cycle, `timeout_o` pulse one cycle later, `s_cyc_o` low. Another master's pending request is granted only after g drops `cyc`.
- **Limit boundary**: ack arrives exactly on the limit cycle → no `err`, no `timeout_o`, and `wdt` restarts from 0.
- **Reset mid-burst**: `rst_i` during beat 2 of a write → next cycle `s_cyc_o` = 0, `grant_o` = 0, and master 0 has priority on the next request.
